// File: rtl/fwd_bypass_buffer_pkg.sv
// Shared definitions for the forwarding bypass buffer: default sizing
// constants, the canonical {valid, idx, data} entry layout, and a helper
// that sizes the forwarding candidate list.
package fwd_bypass_buffer_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_REG_NUM  = 31;
    localparam int DEF_WR_PORTS = 2;
    localparam int DEF_DEPTH    = 3;
    localparam int DEF_IDX_W    = $clog2(DEF_REG_NUM + 1);

    // Canonical buffered-result entry at the default widths. The top builds
    // a width-matched copy of this layout from its own parameters.
    typedef struct packed {
        logic                  valid;
        logic [DEF_IDX_W-1:0]  idx;
        logic [DEF_DATA_W-1:0] data;
    } fwd_entry_t;

    // Forwarding candidates: the live write ports plus every stage slot.
    function automatic int cand_count(input int ports, input int depth);
        return ports * (depth + 1);
    endfunction

endpackage

// File: rtl/fwd_bypass_buffer_prio_select.sv
// Per-register forwarding priority mux. Candidates arrive ordered
// youngest-first (index 0 is the youngest); the youngest valid candidate
// whose idx equals this register's number wins, otherwise the committed
// value passes through. The hit flag exists only when FWD_BYPASS_STATS_EN
// is defined.
module fwd_prio_select #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 5,
    parameter int N_CAND = 8,
    parameter int REG_ID = 0
) (
    input  logic [N_CAND-1:0]             cand_valid,
    input  logic [N_CAND-1:0][IDX_W-1:0]  cand_idx,
    input  logic [N_CAND-1:0][DATA_W-1:0] cand_data,
    input  logic [DATA_W-1:0]             dflt_data,
`ifdef FWD_BYPASS_STATS_EN
    output logic                          hit,
`endif
    output logic [DATA_W-1:0]             sel_data
);

    localparam logic [IDX_W-1:0] MATCH_IDX = IDX_W'(REG_ID);

    // Scan oldest to youngest so the youngest match is the last to assign.
    always_comb begin
        sel_data = dflt_data;
`ifdef FWD_BYPASS_STATS_EN
        hit = 1'b0;
`endif
        for (int c = N_CAND - 1; c >= 0; c--) begin
            if (cand_valid[c] && (cand_idx[c] == MATCH_IDX)) begin
                sel_data = cand_data[c];
`ifdef FWD_BYPASS_STATS_EN
                hit = 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_buffer.sv
// Forwarding bypass buffer: holds execute results in a DEPTH-stage shift
// pipeline until commit, forwards the youngest in-flight value of every
// register, and flags registers with uncommitted writes.
// Optional: define FWD_BYPASS_STATS_EN to enable the forwarding hit counter.
module fwd_bypass_buffer
    import fwd_bypass_buffer_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_NUM  = DEF_REG_NUM,
    parameter int WR_PORTS = DEF_WR_PORTS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush,
    input  logic [WR_PORTS-1:0]                           wr_valid,
    input  logic [WR_PORTS-1:0][$clog2(REG_NUM+1)-1:0]    wr_idx,
    input  logic [WR_PORTS-1:0][DATA_W-1:0]               wr_data,
    input  logic [REG_NUM-1:0][DATA_W-1:0]                reg_in,
    output logic [REG_NUM-1:0][DATA_W-1:0]                reg_out,
    output logic [WR_PORTS-1:0]                           commit_valid,
    output logic [WR_PORTS-1:0][$clog2(REG_NUM+1)-1:0]    commit_idx,
    output logic [WR_PORTS-1:0][DATA_W-1:0]               commit_data,
    output logic [REG_NUM-1:0]                            pending,
    output logic [31:0]                                   fwd_hit_cnt
);

    localparam int IDX_W  = $clog2(REG_NUM + 1);
    localparam int N_CAND = cand_count(WR_PORTS, DEPTH);
    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(REG_NUM);

    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t stage_q [DEPTH][WR_PORTS];
    entry_t stage_d [DEPTH][WR_PORTS];

    logic [N_CAND-1:0]             cand_valid;
    logic [N_CAND-1:0][IDX_W-1:0]  cand_idx;
    logic [N_CAND-1:0][DATA_W-1:0] cand_data;
    logic [DATA_W-1:0]             sel_data [REG_NUM];

    // Shift pipeline next state: load S0 from the write ports, advance the
    // rest; flush empties every stage and drops the incoming writes.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            for (int p = 0; p < WR_PORTS; p++) begin
                stage_d[k][p] = '0;
            end
        end
        if (!flush) begin
            for (int p = 0; p < WR_PORTS; p++) begin
                stage_d[0][p].valid = wr_valid[p] && (wr_idx[p] < IDX_LIMIT);
                stage_d[0][p].idx   = wr_idx[p];
                stage_d[0][p].data  = wr_data[p];
            end
            for (int k = 1; k < DEPTH; k++) begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    stage_d[k][p] = stage_q[k-1][p];
                end
            end
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    stage_q[k][p] <= '0;
                end
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    // Candidate list, youngest first: write ports (high port first), then
    // S0..S(DEPTH-1). Flush masks all of them so reg_out falls to reg_in.
    always_comb begin
        for (int p = 0; p < WR_PORTS; p++) begin
            cand_valid[WR_PORTS-1-p] = wr_valid[p] && (wr_idx[p] < IDX_LIMIT) && !flush;
            cand_idx[WR_PORTS-1-p]   = wr_idx[p];
            cand_data[WR_PORTS-1-p]  = wr_data[p];
            for (int k = 0; k < DEPTH; k++) begin
                cand_valid[(k+1)*WR_PORTS + (WR_PORTS-1-p)] = stage_q[k][p].valid && !flush;
                cand_idx[(k+1)*WR_PORTS + (WR_PORTS-1-p)]   = stage_q[k][p].idx;
                cand_data[(k+1)*WR_PORTS + (WR_PORTS-1-p)]  = stage_q[k][p].data;
            end
        end
    end

`ifdef FWD_BYPASS_STATS_EN
    logic sel_hit [REG_NUM];
`endif

    for (genvar i = 0; i < REG_NUM; i++) begin : g_sel
        fwd_prio_select #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W),
            .N_CAND (N_CAND),
            .REG_ID (i)
        ) u_sel (
            .cand_valid (cand_valid),
            .cand_idx   (cand_idx),
            .cand_data  (cand_data),
            .dflt_data  (reg_in[i]),
`ifdef FWD_BYPASS_STATS_EN
            .hit        (sel_hit[i]),
`endif
            .sel_data   (sel_data[i])
        );
    end

    // Gather the per-register selections onto the output bus.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            reg_out[i] = sel_data[i];
        end
    end

    // A register is pending while any stage holds a valid write to it.
    always_comb begin
        pending = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (stage_q[k][p].valid && (stage_q[k][p].idx == IDX_W'(i))) begin
                        pending[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Commit from the last stage; an older port loses to a younger port
    // writing the same register so only the youngest value retires.
    always_comb begin
        for (int p = 0; p < WR_PORTS; p++) begin
            commit_valid[p] = stage_q[DEPTH-1][p].valid;
            commit_idx[p]   = stage_q[DEPTH-1][p].idx;
            commit_data[p]  = stage_q[DEPTH-1][p].data;
            for (int q = p + 1; q < WR_PORTS; q++) begin
                if (stage_q[DEPTH-1][q].valid &&
                    (stage_q[DEPTH-1][q].idx == stage_q[DEPTH-1][p].idx)) begin
                    commit_valid[p] = 1'b0;
                end
            end
        end
    end

`ifdef FWD_BYPASS_STATS_EN
    logic        any_hit;
    logic [31:0] fwd_hit_cnt_q;
    logic [31:0] fwd_hit_cnt_d;

    // Count non-flush cycles where at least one register was bypassed.
    always_comb begin
        any_hit = 1'b0;
        for (int i = 0; i < REG_NUM; i++) begin
            any_hit = any_hit | sel_hit[i];
        end
        fwd_hit_cnt_d = fwd_hit_cnt_q + ((any_hit && !flush) ? 32'd1 : 32'd0);
    end

    // Hit counter register, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit_cnt_q <= '0;
        end else begin
            fwd_hit_cnt_q <= fwd_hit_cnt_d;
        end
    end

    assign fwd_hit_cnt = fwd_hit_cnt_q;
`else
    assign fwd_hit_cnt = '0;
`endif

endmodule
